parity_checker_rx: RTL and testbench
====================================

# parity_checker_rx

Serial receiver and checker for parity-protected frames, at the receive end of the parity generator link. It takes a one-bit-per-strobe serial line carrying start bit, DATA_W data bits (LSB first), parity bit and stop bit. It deserialises the data word and recomputes parity over the data plus the received parity bit. It then presents the word with parity and framing error flags for one cycle.

## Interface
- DATA_W, 3: data bits per frame (1..16).
- ODD, 0: 0 = even parity, where the XOR of data and parity bits must be 0; 1 = odd parity, where it must be 1.
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset; synchronous and active-high.
- rx  input  1  serial line; idle level 1.
- in_valid  input  1  rx holds a valid bit this cycle; cycles with in_valid=0 are ignored.
- data  output  DATA_W  received word; valid only while out_valid=1.
- out_valid  output  1  one-cycle pulse per completed frame.
- parity_err  output  1  parity mismatch for the frame; qualified by out_valid.
- frame_err  output  1  stop bit was 0; qualified by out_valid.
- busy  output  1  high from start-bit accept until the stop bit is consumed.

## Operation
- States: IDLE, DATA, PAR, STOP.
- IDLE, on in_valid with rx=0 (start bit):
  - go to DATA;
  - clear bit counter, shift register and running parity.
- IDLE, on in_valid with rx=1: stay in IDLE; the line is idle.
- DATA, on each in_valid:
  - shift rx into bit position cnt (LSB first);
  - update running parity with acc ^= rx;
  - cnt++;
  - after DATA_W bits, go to PAR.
- PAR, on in_valid:
  - acc ^= rx;
  - latch err = (acc_new != ODD);
  - go to STOP.
- STOP, on in_valid:
  - frame_err = ~rx;
  - register data, parity_err, frame_err;
  - pulse out_valid;
  - go to IDLE.
- A frame error does not discard the data. Resynchronisation is done by the next start bit seen in IDLE.
- in_valid=0 in any state: hold state, counter and accumulator unchanged.
- Counter width is $clog2(DATA_W+1). The counter never wraps, because DATA exits at cnt==DATA_W-1 on accept.
- busy = (state != IDLE).

## Timing
- Reset (rst=1 at a clock edge):
  - state goes to IDLE;
  - data=0, out_valid=0, parity_err=0, frame_err=0, busy=0;
  - counter and accumulator cleared.
  - Reset mid-frame abandons the frame with no out_valid.
- Latency: out_valid is high in the cycle after the edge that samples the stop bit. It is high for exactly one cycle.
- data, parity_err and frame_err hold their values until the next out_valid; they are qualified only by out_valid.
- Back-to-back frames: a start bit may arrive on the first in_valid after the stop bit. The out_valid pulse for the previous frame coincides with the accept of the new start bit; both happen in the same cycle.
- Minimum frame: DATA_W+3 accepted bits. With in_valid held high, one frame takes DATA_W+3 cycles.
- rst has priority over in_valid in the same cycle.

## Structure
- Shared package parity_pkg holds:
  - the state typedef (IDLE, DATA, PAR, STOP);
  - the constants PAR_EVEN=0 and PAR_ODD=1, shared with the generator side.
- No sub-module: parity is a single running-XOR flop, and the deserialiser is an indexed shift register inside the FSM block.
- Companion bench-only serialiser task: drives a frame given data, a parity override and a stop-bit override.

## Test plan
- Clean frame, DATA_W=3, ODD=0, in_valid=1:
  - stimulus: data 3'b101 sent as bits 0,1,0,1,0,1;
  - required: out_valid one cycle later, data=5, parity_err=0, frame_err=0;
  - repeat for all 8 values with correct even parity: data matches and no errors.
- Parity corruption:
  - stimulus: send 3'b011 with parity bit 1 instead of 0;
  - required: data=3, parity_err=1, frame_err=0.
  - With ODD=1, the same frame carrying parity 1 gives parity_err=0.
- Framing error:
  - stimulus: send 3'b110 with correct parity 0 and stop bit 0;
  - required: data=6, frame_err=1, parity_err=0;
  - a following clean frame for 3'b001 then reports data=1 with no errors.
- Stall and idle:
  - stimulus: insert 2 cycles of in_valid=0 after d1, and keep rx=1 for 5 accepted idle bits before the start bit;
  - required: result identical to the unstalled frame; busy=0 throughout the idle bits.
- Reset mid-frame:
  - stimulus: assert rst for one cycle after d1 of a frame;
  - required: no out_valid; all outputs 0 the next cycle; busy=0;
  - a subsequent frame for 3'b111 with parity 1 gives data=7 and no errors.
- Back-to-back:
  - stimulus: two frames with no gap, 3'b010 then 3'b100;
  - required: two out_valid pulses exactly 6 cycles apart, data=2 then data=4.

Source files
------------

// File: rtl/parity_pkg.sv
// Definitions shared by the parity generator and the parity checker ends of the link.
// The state type also drives the receiver's debug state port.
package parity_pkg;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } parity_state_e;

endpackage

// File: rtl/parity_checker_rx_if.sv
// Serial-in / word-out bundle for the parity checking receiver.
// Includes the receiver FSM state as a debug output.
interface parity_checker_rx_if #(
    parameter int DATA_W = 3
) ();
    import parity_pkg::*;

    // Handshake: a bit on rx is consumed on every rising edge where in_valid=1.
    // The receiver cannot stall the line, so there is no ready signal.
    // out_valid is a one-cycle pulse that qualifies data, parity_err and frame_err.
    logic              rx;
    logic              in_valid;
    logic [DATA_W-1:0] data;
    logic              out_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
    parity_state_e     state;

    modport master (
        output rx, in_valid,
        input  data, out_valid, parity_err, frame_err, busy, state
    );

    modport slave (
        input  rx, in_valid,
        output data, out_valid, parity_err, frame_err, busy, state
    );

endinterface

// File: rtl/parity_checker_rx.sv
// Deserialises start/data(LSB first)/parity/stop frames and checks them.
// Reports the word with parity and framing error flags as a one-cycle pulse.
module parity_checker_rx
    import parity_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int ODD    = PAR_EVEN
) (
    input  logic                clk,
    input  logic                rst,
    parity_checker_rx_if.slave  bus
);

    localparam int   CNT_W   = $clog2(DATA_W + 1);
    localparam logic ODD_BIT = (ODD == PAR_ODD);

    parity_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_q, acc_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              out_valid_q, out_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            data_q       <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            perr_q       <= perr_d;
            data_q       <= data_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        perr_d       = perr_q;
        data_d       = data_q;
        out_valid_d  = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (bus.in_valid) begin
            case (state_q)
                IDLE: begin
                    if (!bus.rx) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                        acc_d   = 1'b0;
                    end
                end
                DATA: begin
                    // The shift register is cleared at the start bit, so OR-ing in place is enough.
                    shift_d = shift_q | (DATA_W'(bus.rx) << cnt_q);
                    acc_d   = acc_q ^ bus.rx;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    acc_d   = acc_q ^ bus.rx;
                    perr_d  = (acc_q ^ bus.rx) != ODD_BIT;
                    state_d = STOP;
                end
                STOP: begin
                    // A bad stop bit is flagged, but the word is still delivered.
                    data_d       = shift_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ~bus.rx;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_parity_checker_rx.sv
// Scoreboard bench for parity_checker_rx: even and odd instances share one serial line.
// A frame-level reference model predicts the results for both instances.
module tb_parity_checker_rx;

    localparam int DW = 3;
    localparam int W  = DW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic in_valid = 1'b0;
    int   cyc = 0;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    int           cyc0_q[$];
    int           cyc1_q[$];
    int           last_ov = 0;
    int           prev_ov = 0;

    parity_checker_rx_if #(.DATA_W(DW)) bus0 ();
    parity_checker_rx_if #(.DATA_W(DW)) bus1 ();

    assign bus0.rx       = rx;
    assign bus0.in_valid = in_valid;
    assign bus1.rx       = rx;
    assign bus1.in_valid = in_valid;

    parity_checker_rx #(.DATA_W(DW), .ODD(0)) dut_even (.clk(clk), .rst(rst), .bus(bus0));
    parity_checker_rx #(.DATA_W(DW), .ODD(1)) dut_odd  (.clk(clk), .rst(rst), .bus(bus1));

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // driver tasks
    task automatic send_bit(input logic b);
        rx = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            rx = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: parity error when the data+parity XOR differs from the configured sense.
    task automatic send_frame(input logic [DW-1:0] d, input logic flip, input logic stop_b,
                              input int stall_n);
        logic p;
        int   ones;
        ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(d[i]);
        p = logic'(ones % 2) ^ flip;
        exp0_q.push_back({d, logic'(((ones + int'(p)) % 2) != 0), ~stop_b});
        exp1_q.push_back({d, logic'(((ones + int'(p)) % 2) != 1), ~stop_b});
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            send_bit(d[i]);
            if (i == 1 && stall_n > 0) stall(stall_n);
        end
        send_bit(p);
        send_bit(stop_b);
        cyc0_q.push_back(cyc);
        cyc1_q.push_back(cyc);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        logic [W-1:0] e;
        int c;
        if (bus0.out_valid) begin
            check("even_expected_pending", 32'(exp0_q.size() != 0), 32'd1);
            if (exp0_q.size() != 0) begin
                e = exp0_q.pop_front();
                c = cyc0_q.pop_front();
                check("even_data", 32'(bus0.data), 32'(e[W-1:2]));
                check("even_parity_err", 32'(bus0.parity_err), 32'(e[1]));
                check("even_frame_err", 32'(bus0.frame_err), 32'(e[0]));
                check("even_latency", 32'(cyc), 32'(c));
            end
            prev_ov = last_ov;
            last_ov = cyc;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        int c;
        if (bus1.out_valid) begin
            check("odd_expected_pending", 32'(exp1_q.size() != 0), 32'd1);
            if (exp1_q.size() != 0) begin
                e = exp1_q.pop_front();
                c = cyc1_q.pop_front();
                check("odd_data", 32'(bus1.data), 32'(e[W-1:2]));
                check("odd_parity_err", 32'(bus1.parity_err), 32'(e[1]));
                check("odd_frame_err", 32'(bus1.frame_err), 32'(e[0]));
                check("odd_latency", 32'(cyc), 32'(c));
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(bus0.data), 32'd0);
        check("reset_out_valid", 32'(bus0.out_valid), 32'd0);
        check("reset_parity_err", 32'(bus0.parity_err), 32'd0);
        check("reset_frame_err", 32'(bus0.frame_err), 32'd0);
        check("reset_busy", 32'(bus0.busy), 32'd0);
        rst = 1'b0;
        stall(2);

        // every value with correct parity
        for (int v = 0; v < 8; v++) send_frame(3'(v), 1'b0, 1'b1, 0);
        stall(2);

        // parity corruption: 3'b011 with parity bit 1
        send_frame(3'b011, 1'b1, 1'b1, 0);
        stall(2);

        // framing error followed by a clean frame
        send_frame(3'b110, 1'b0, 1'b0, 0);
        send_frame(3'b001, 1'b0, 1'b1, 0);
        stall(2);

        // idle bits then a stalled frame
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            check("idle_busy", 32'(bus0.busy), 32'd0);
        end
        send_frame(3'b101, 1'b0, 1'b1, 2);
        stall(2);

        // reset after d1 of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("midframe_busy", 32'(bus0.busy), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_data", 32'(bus0.data), 32'd0);
        check("midreset_out_valid", 32'(bus0.out_valid), 32'd0);
        check("midreset_parity_err", 32'(bus0.parity_err), 32'd0);
        check("midreset_frame_err", 32'(bus0.frame_err), 32'd0);
        check("midreset_busy", 32'(bus0.busy), 32'd0);
        stall(2);
        send_frame(3'b111, 1'b0, 1'b1, 0);
        stall(2);

        // back-to-back frames
        send_frame(3'b010, 1'b0, 1'b1, 0);
        send_frame(3'b100, 1'b0, 1'b1, 0);
        stall(3);
        check("b2b_gap", 32'(last_ov - prev_ov), 32'd6);

        // randomized frames
        for (int n = 0; n < 30; n++) begin
            send_frame(3'($urandom_range(0, 7)), logic'($urandom_range(0, 3) == 0),
                       logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
            stall(int'($urandom_range(0, 2)));
        end
        stall(4);

        check("even_queue_drained", 32'(exp0_q.size()), 32'd0);
        check("odd_queue_drained", 32'(exp1_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
